// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: FSM states,
// decoded opcode/funct values and datapath select codes.
package mips_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_FETCH_REQ = 4'd0;
    localparam state_t ST_DECODE    = 4'd1;
    localparam state_t ST_EXEC_R    = 4'd2;
    localparam state_t ST_EXEC_I    = 4'd3;
    localparam state_t ST_WB_ALU    = 4'd4;
    localparam state_t ST_MEM_ADDR  = 4'd5;
    localparam state_t ST_MEM_RD    = 4'd6;
    localparam state_t ST_MEM_WR    = 4'd7;
    localparam state_t ST_WB_MEM    = 4'd8;
    localparam state_t ST_BRANCH    = 4'd9;
    localparam state_t ST_JUMP      = 4'd10;
    localparam state_t ST_ILLEGAL   = 4'd11;
    localparam state_t ST_TIMEOUT   = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    localparam logic [1:0] PC_SRC_PC4    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] ALUB_RT     = 2'd0;
    localparam logic [1:0] ALUB_FOUR   = 2'd1;
    localparam logic [1:0] ALUB_IMM    = 2'd2;
    localparam logic [1:0] ALUB_IMM_SH = 2'd3;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/mips_alu_decode.sv
// R-type funct field to ALU operation; unknown funct raises illegal_funct.
module mips_alu_decode
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       illegal_funct
);

    always_comb begin
        alu_op        = ALU_ADD;
        illegal_funct = 1'b0;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: illegal_funct = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM. Outputs are decoded from the registered state and
// the IR opcode/funct; memory states stall on mem_ready and time out after MEM_TIMEOUT.
module mips_mc_control
    import mips_pkg::*;
#(
    parameter int         MEM_TIMEOUT  = 16,
    parameter logic [1:0] RESET_PC_SEL = 2'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       branch,
    output logic       jump,
    output logic       retired,
    output logic [1:0] err,
    output logic [3:0] dbg_state
);

    state_t     state_q, state_d;
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic [2:0] fn_alu_op;
    logic       fn_illegal;
    logic       in_req;
    logic       tmo_hit;

    mips_alu_decode u_alu_decode (
        .funct         (funct),
        .alu_op        (fn_alu_op),
        .illegal_funct (fn_illegal)
    );

    assign in_req    = (state_q == ST_FETCH_REQ) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);
    assign tmo_hit   = ({1'b0, tmo_cnt_q} + 9'd1) >= 9'(MEM_TIMEOUT);
    assign dbg_state = state_q;

    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = '0;
        case (state_q)
            ST_FETCH_REQ: if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:          state_d = ST_EXEC_R;
                    OP_ADDI, OP_ADDIU: state_d = ST_EXEC_I;
                    OP_LW, OP_SW:      state_d = ST_MEM_ADDR;
                    OP_BEQ:            state_d = ST_BRANCH;
                    OP_J:              state_d = ST_JUMP;
                    default:           state_d = ST_ILLEGAL;
                endcase
            end
            ST_EXEC_R:   state_d = fn_illegal ? ST_ILLEGAL : ST_WB_ALU;
            ST_EXEC_I:   state_d = ST_WB_ALU;
            ST_MEM_ADDR: state_d = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   if (mem_ready) state_d = ST_WB_MEM;
            ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH_REQ;
            ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JUMP: state_d = ST_FETCH_REQ;
            default:     state_d = state_q;
        endcase
        // A ready on the same edge the count expires takes priority over the timeout.
        if (in_req && !mem_ready) begin
            if (tmo_hit) state_d   = ST_TIMEOUT;
            else         tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH_REQ;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // Outputs are forced idle while rst_n is low so no write escapes an abort.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_PC4;
        alu_src_a  = 1'b0;
        alu_src_b  = ALUB_RT;
        alu_op     = ALU_ADD;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        retired    = 1'b0;
        err        = ERR_NONE;
        if (!rst_n) begin
            pc_src = RESET_PC_SEL;
        end else begin
            case (state_q)
                ST_FETCH_REQ: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write  = 1'b1;
                        pc_write  = 1'b1;
                        alu_src_b = ALUB_FOUR;
                    end
                end
                ST_DECODE: alu_src_b = ALUB_IMM_SH;
                ST_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = fn_alu_op;
                end
                ST_EXEC_I: alu_src_b = ALUB_IMM;
                ST_WB_ALU: begin
                    reg_write = 1'b1;
                    reg_dst   = (opcode == OP_RTYPE);
                    retired   = 1'b1;
                end
                ST_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALUB_IMM;
                end
                ST_MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                ST_MEM_WR: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = 1'b1;
                    retired = mem_ready;
                end
                ST_WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    retired    = 1'b1;
                end
                ST_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    branch    = 1'b1;
                    pc_src    = PC_SRC_BRANCH;
                    pc_write  = zero;
                    retired   = 1'b1;
                end
                ST_JUMP: begin
                    jump     = 1'b1;
                    pc_src   = PC_SRC_JUMP;
                    pc_write = 1'b1;
                    retired  = 1'b1;
                end
                ST_ILLEGAL: err = ERR_ILLEGAL;
                ST_TIMEOUT: err = ERR_TIMEOUT;
                default: ;
            endcase
        end
    end

endmodule
